mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one synchronous single-port word memory between the core's instruction-fetch port and its load/store port, so the processor `top` can run from a unified memory instead of split instruction and data arrays. It grants at most one access per cycle using two-way round-robin and returns read data and a response strobe one cycle later. Out-of-range and misaligned addresses are rejected with an error response and never reach the memory.

## Interface
- `WIDTH`, 32, data and byte-address width.
- `DEPTH`, 20, memory size in words; valid byte addresses are 0 .. 4*DEPTH-1.
- `AW`, derived as `$clog2(DEPTH)`, memory word-address width.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held with stable `if_addr` until granted.
- `if_addr` in WIDTH: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch response valid.
- `if_rdata` out WIDTH: fetch read data.
- `if_err` out 1: fetch response is an error.
- `d_req` in 1: data request; held with stable `d_we`, `d_addr` and `d_wdata` until granted.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in WIDTH: data byte address.
- `d_wdata` in WIDTH: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data response valid (loads and stores).
- `d_rdata` out WIDTH: load data.
- `d_err` out 1: data response is an error.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory word address.
- `mem_wdata` out WIDTH: memory write data.
- `mem_rdata` in WIDTH: memory read data, valid the cycle after `mem_en & !mem_we`.

## Operation
- **Arbitration**
  - One request pending: it wins.
  - Both pending: the port that did not win last wins.
  - `last_winner` updates only on a grant. Its reset value is DATA, so the first tie goes to fetch.
- **Grant**
  - `if_gnt`/`d_gnt` are combinational from the requests and `last_winner`.
  - Exactly one grant is asserted when any request is present, and never both.
  - A request is retired the cycle its grant is high.
- **Address check**
  - Legal means `addr[1:0]==0` and `addr[WIDTH-1:2] < DEPTH`.
  - Legal grant: `mem_en=1`, `mem_addr=addr[AW+1:2]`, `mem_we=d_we` for data (0 for fetch), `mem_wdata=d_wdata`.
  - Illegal grant: still granted, but `mem_en=0`. It produces an error response.
- **Response pipeline**
  - Registered `resp_valid`, `resp_owner`, `resp_err`, captured on each grant.
  - Next cycle, the owner's `*_rvalid=1`.
  - `*_rdata` is `mem_rdata` for a legal load or fetch, and 0 for stores and errors.
  - `*_err=resp_err`.
  - The non-owner's rvalid, rdata and err are all 0.
- **Stores** get an ack response (`d_rvalid=1`, `d_rdata=0`).
- **Idle cycles:** with no request, `mem_en=0` and no response the following cycle.

## Timing
- **Reset values:** `last_winner=DATA`, `resp_valid=0`, `resp_err=0`. All outputs are 0 during reset, including `*_gnt`, because grants are gated by `!rst`.
- **Latency:** request granted in cycle N gives the response in cycle N+1. Throughput is one access per cycle; back-to-back grants to alternating or the same port are allowed.
- **Contention:** with both ports requesting continuously, grants alternate IF, D, IF, D… and neither port waits more than 1 cycle.
- **Simultaneous events:** a response for grant N and a new grant N+1 occur in the same cycle. Both are legal and independent.
- **Reset mid-operation:** an outstanding response is dropped (no rvalid after reset). After reset deassertion, arbitration resumes with `last_winner=DATA`.
- **Requester rules:** dropping `req` before its grant is a protocol violation. Behaviour is undefined but must not produce a grant while `req=0`.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {OWN_IF, OWN_D} owner_t`
  - the response-register struct (valid, owner, err, is_write)
  - the function `addr_legal(addr, DEPTH)`
- Sub-module `rr_arbiter2`: two requests in, one-hot grant out, internal `last_winner` flop with async reset. `mem_port_arbiter` instantiates it and adds the address check, memory drive and response pipeline.

## Test plan
- **Fetch only:** `if_req` at `if_addr=0x8` with `mem_rdata=0xDEADBEEF` next cycle → `if_gnt=1`, `mem_addr=2`, then `if_rvalid=1`, `if_rdata=0xDEADBEEF`, `if_err=0`.
- **Tie after reset:** `if_req` and `d_req` (load 0x10) both held for 4 cycles → grant order IF, D, IF, D; `mem_addr` sequence matches; responses arrive one cycle later to the correct owner.
- **Store ack:** `d_req`, `d_we=1`, `d_addr=0x4C`, `d_wdata=0x12345678` → `mem_en=1`, `mem_we=1`, `mem_addr=19`, `mem_wdata=0x12345678`; next cycle `d_rvalid=1`, `d_rdata=0`, `d_err=0`.
- **Error cases:**
  - `d_addr=0x50` (word 20 = DEPTH) → `d_gnt=1`, `mem_en=0`; next cycle `d_rvalid=1`, `d_err=1`, `d_rdata=0`.
  - `if_addr=0x6` (misaligned) → same error response on the IF side.
- **Reset mid-op:** grant a load, assert `rst` before the next edge → no `d_rvalid`. After release, a tie grants IF first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_arb_pkg;

   localparam int ADDR_MAX = 64;

   typedef enum logic {OWN_IF, OWN_D} owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   err;
      logic   is_write;
   } resp_t;

   // Word aligned and inside the memory; callers zero-extend their address.
   function automatic logic addr_legal(input logic [ADDR_MAX-1:0] addr,
                                       input int unsigned         depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < ADDR_MAX'(depth));
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last winner loses a tie.
// Latency: grant is combinational from the requests in the same cycle.
// Backpressure: a losing request is expected to hold until it is granted.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_if,
   input  logic req_d,
   output logic gnt_if,
   output logic gnt_d
);

   owner_t last_winner;

   always_comb begin
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
      if (!rst) begin
         if (req_if && req_d) begin
            if (last_winner == OWN_D) gnt_if = 1'b1;
            else                      gnt_d  = 1'b1;
         end else begin
            gnt_if = req_if;
            gnt_d  = req_d;
         end
      end
   end

   // Reset to DATA so the first tie after reset goes to fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_winner <= OWN_D;
      end else if (gnt_if || gnt_d) begin
         last_winner <= gnt_d ? OWN_D : OWN_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between fetch and load/store ports.
// Latency: grant same cycle, response (rvalid/rdata/err) one cycle later.
// Backpressure: one access per cycle; the losing port holds its request.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 20,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_err,

   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_err,

   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   logic             any_gnt;
   logic [WIDTH-1:0] sel_addr;
   logic             sel_legal;
   logic [WIDTH-1:0] rdata_sel;
   resp_t            resp_d;
   resp_t            resp_q;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_if (if_req),
      .req_d  (d_req),
      .gnt_if (if_gnt),
      .gnt_d  (d_gnt)
   );

   assign any_gnt   = if_gnt | d_gnt;
   assign sel_addr  = d_gnt ? d_addr : if_addr;
   assign sel_legal = addr_legal(ADDR_MAX'(sel_addr), DEPTH);

   // Illegal accesses are still granted but never touch the memory.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (any_gnt && sel_legal) begin
         mem_en    = 1'b1;
         mem_we    = d_gnt & d_we;
         mem_addr  = sel_addr[AW+1:2];
         mem_wdata = d_wdata;
      end
   end

   always_comb begin
      resp_d          = '0;
      resp_d.valid    = any_gnt;
      resp_d.owner    = d_gnt ? OWN_D : OWN_IF;
      resp_d.err      = any_gnt & ~sel_legal;
      resp_d.is_write = d_gnt & d_we;
   end

   // Async reset drops any outstanding response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_q <= '0;
      end else begin
         resp_q <= resp_d;
      end
   end

   // Stores and errors return zero data regardless of the memory bus.
   assign rdata_sel = (resp_q.valid && !resp_q.err && !resp_q.is_write) ? mem_rdata : '0;

   assign if_rvalid = resp_q.valid && (resp_q.owner == OWN_IF);
   assign if_rdata  = if_rvalid ? rdata_sel : '0;
   assign if_err    = if_rvalid & resp_q.err;

   assign d_rvalid  = resp_q.valid && (resp_q.owner == OWN_D);
   assign d_rdata   = d_rvalid ? rdata_sel : '0;
   assign d_err     = d_rvalid & resp_q.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 20;
   localparam int AW    = $clog2(DEPTH);

   logic             clk;
   logic             rst;
   logic             if_req;
   logic [WIDTH-1:0] if_addr;
   logic             if_gnt;
   logic             if_rvalid;
   logic [WIDTH-1:0] if_rdata;
   logic             if_err;
   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic             d_gnt;
   logic             d_rvalid;
   logic [WIDTH-1:0] d_rdata;
   logic             d_err;
   logic             mem_en;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [31:0] rd);
      if_req    = ir;
      if_addr   = ia;
      d_req     = dr;
      d_we      = dw;
      d_addr    = da;
      d_wdata   = dwd;
      mem_rdata = rd;
   endtask

   task automatic idle(input logic [31:0] rd);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, rd);
   endtask

   initial begin
      logic        exp_if;
      logic [31:0] rd;

      rst = 1'b1;
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFFF);
      #2;
      chk("reset_if_gnt",   32'(if_gnt),    32'd0);
      chk("reset_d_gnt",    32'(d_gnt),     32'd0);
      chk("reset_mem_en",   32'(mem_en),    32'd0);
      chk("reset_if_rvld",  32'(if_rvalid), 32'd0);
      chk("reset_d_rvld",   32'(d_rvalid),  32'd0);
      next_cycle();
      idle(32'h0);
      next_cycle();
      rst = 1'b0;

      // Fetch only.
      next_cycle();
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #4;
      chk("fetch_if_gnt",   32'(if_gnt),   32'd1);
      chk("fetch_d_gnt",    32'(d_gnt),    32'd0);
      chk("fetch_mem_en",   32'(mem_en),   32'd1);
      chk("fetch_mem_we",   32'(mem_we),   32'd0);
      chk("fetch_mem_addr", 32'(mem_addr), 32'd2);
      next_cycle();
      idle(32'hDEAD_BEEF);
      #4;
      chk("fetch_rvalid",   32'(if_rvalid), 32'd1);
      chk("fetch_rdata",    if_rdata,       32'hDEAD_BEEF);
      chk("fetch_err",      32'(if_err),    32'd0);
      chk("fetch_d_rvalid", 32'(d_rvalid),  32'd0);
      chk("idle_mem_en",    32'(mem_en),    32'd0);
      next_cycle();
      idle(32'h5555_5555);
      #4;
      chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("idle_d_rvalid",  32'(d_rvalid),  32'd0);

      // Fresh reset, then a continuous tie: IF, D, IF, D.
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         rd = 32'h1000 + 32'(k);
         if (k < 4) drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'h0, rd);
         else       idle(rd);
         #4;
         if (k < 4) begin
            exp_if = (k % 2 == 0);
            chk($sformatf("tie%0d_if_gnt", k), 32'(if_gnt), 32'(exp_if));
            chk($sformatf("tie%0d_d_gnt", k),  32'(d_gnt),  32'(!exp_if));
            chk($sformatf("tie%0d_mem_addr", k), 32'(mem_addr), exp_if ? 32'd1 : 32'd4);
         end
         if (k > 0) begin
            exp_if = ((k - 1) % 2 == 0);
            chk($sformatf("tie%0d_if_rvalid", k), 32'(if_rvalid), 32'(exp_if));
            chk($sformatf("tie%0d_d_rvalid", k),  32'(d_rvalid),  32'(!exp_if));
            chk($sformatf("tie%0d_rdata", k), exp_if ? if_rdata : d_rdata, rd);
         end
      end

      // Store to the last word.
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h4C, 32'h1234_5678, 32'h0);
      #4;
      chk("st_d_gnt",     32'(d_gnt),    32'd1);
      chk("st_mem_en",    32'(mem_en),   32'd1);
      chk("st_mem_we",    32'(mem_we),   32'd1);
      chk("st_mem_addr",  32'(mem_addr), 32'd19);
      chk("st_mem_wdata", mem_wdata,     32'h1234_5678);
      next_cycle();
      idle(32'hFFFF_FFFF);
      #4;
      chk("st_rvalid", 32'(d_rvalid), 32'd1);
      chk("st_rdata",  d_rdata,       32'h0);
      chk("st_err",    32'(d_err),    32'd0);

      // Load one word past the end.
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0);
      #4;
      chk("oor_d_gnt",  32'(d_gnt),  32'd1);
      chk("oor_mem_en", 32'(mem_en), 32'd0);
      next_cycle();
      idle(32'hFFFF_FFFF);
      #4;
      chk("oor_rvalid", 32'(d_rvalid), 32'd1);
      chk("oor_err",    32'(d_err),    32'd1);
      chk("oor_rdata",  d_rdata,       32'h0);

      // Misaligned fetch.
      next_cycle();
      drive(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #4;
      chk("mis_if_gnt", 32'(if_gnt), 32'd1);
      chk("mis_mem_en", 32'(mem_en), 32'd0);
      next_cycle();
      idle(32'hFFFF_FFFF);
      #4;
      chk("mis_rvalid",   32'(if_rvalid), 32'd1);
      chk("mis_err",      32'(if_err),    32'd1);
      chk("mis_rdata",    if_rdata,       32'h0);
      chk("mis_d_rvalid", 32'(d_rvalid),  32'd0);

      // Reset between a grant and its response.
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
      #4;
      chk("rmid_d_gnt", 32'(d_gnt), 32'd1);
      rst = 1'b1;
      drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'h0, 32'hAAAA_AAAA);
      next_cycle();
      #4;
      chk("rmid_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rmid_if_gnt",   32'(if_gnt),   32'd0);
      chk("rmid_d_gnt_rst", 32'(d_gnt),   32'd0);
      next_cycle();
      rst = 1'b0;
      #4;
      chk("rmid_tie_if_gnt", 32'(if_gnt), 32'd1);
      chk("rmid_tie_d_gnt",  32'(d_gnt),  32'd0);
      next_cycle();
      idle(32'h0);
      #4;
      chk("rmid_tie_if_rvalid", 32'(if_rvalid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
